// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for mem_addr_arbiter (MEM_ARB_RR_EN selects round-robin)
package mem_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic int calc_idw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way grant picker; round-robin with MEM_ARB_RR_EN, fixed priority (index 0 first) otherwise
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int N_REQ = 3,
    localparam int IDW   = calc_idw(N_REQ)
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   idx
);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   cand;
    logic           found;

    // Scan N_REQ slots starting at ptr, wrapping without a modulo operator.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDW-1:0];
            end
        end
        if (found && en) begin
            gnt[idx] = 1'b1;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (idx == IDW'(N_REQ-1)) ? '0 : idx + 1'b1;
        end
    end
`else
    logic unused_clk_rst;
    assign ptr            = '0;
    assign unused_clk_rst = clk ^ arstn;
`endif

endmodule

// File: rtl/mem_addr_arbiter.sv
// rtl/mem_addr_arbiter.sv - N-requester address arbiter with one-entry registered output stage
// Arbitration policy follows MEM_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module mem_addr_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int N_REQ      = 3,
    localparam int IDW        = calc_idw(N_REQ)
) (
    input  logic                              clk,
    input  logic                              arstn,
    input  logic [N_REQ-1:0]                  i_req_valid,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]  i_req_addr,
    output logic [N_REQ-1:0]                  o_req_ready,
    output logic                              o_mem_valid,
    output logic [ADDR_WIDTH-1:0]             o_mem_addr,
    output logic [IDW-1:0]                    o_mem_id,
    input  logic                              i_mem_ready
);

    state_t         state;
    logic           can_load;
    logic           hs;
    logic [IDW-1:0] win_idx;

    // Gating with arstn keeps every ready bit low while reset is held.
    assign can_load    = arstn & (~o_mem_valid | i_mem_ready);
    assign hs          = |o_req_ready;
    assign o_mem_valid = (state == FULL);

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk   (clk),
        .arstn (arstn),
        .req   (i_req_valid),
        .en    (can_load),
        .gnt   (o_req_ready),
        .idx   (win_idx)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state      <= EMPTY;
            o_mem_addr <= '0;
            o_mem_id   <= '0;
        end else begin
            if (hs) begin
                o_mem_addr <= i_req_addr[win_idx];
                o_mem_id   <= win_idx;
            end
            case (state)
                EMPTY: if (hs) state <= FULL;
                FULL:  if (!hs && i_mem_ready) state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_addr_arbiter.sv
// tb/tb_mem_addr_arbiter.sv - self-checking bench for mem_addr_arbiter (MEM_ARB_RR_EN aware)
module tb_mem_addr_arbiter;

    logic             clk = 1'b0;
    logic             arstn;
    logic [2:0]       i_req_valid;
    logic [2:0][31:0] i_req_addr;
    logic [2:0]       o_req_ready;
    logic             o_mem_valid;
    logic [31:0]      o_mem_addr;
    logic [1:0]       o_mem_id;
    logic             i_mem_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] addr_tab [3];
    logic [33:0] q [$];
    logic        m_valid;
    logic [31:0] m_addr;
    logic [1:0]  m_id;
    int          m_ptr;

    mem_addr_arbiter #(
        .ADDR_WIDTH (32),
        .N_REQ      (3)
    ) dut (
        .clk         (clk),
        .arstn       (arstn),
        .i_req_valid (i_req_valid),
        .i_req_addr  (i_req_addr),
        .o_req_ready (o_req_ready),
        .o_mem_valid (o_mem_valid),
        .o_mem_addr  (o_mem_addr),
        .o_mem_id    (o_mem_id),
        .i_mem_ready (i_mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_addr  = '0;
        m_id    = '0;
        m_ptr   = 0;
        q.delete();
    endtask

    // One cycle: drive at negedge, check ready, predict, check registered outputs after posedge.
    task automatic step(input logic [2:0] v, input logic mr);
        int          w;
        logic        can;
        logic        hs;
        logic [2:0]  er;
        logic [33:0] e;
        @(negedge clk);
        i_req_valid = v;
        i_mem_ready = mr;
        for (int r = 0; r < 3; r++) i_req_addr[r] = addr_tab[r];
        #1;
        can = !m_valid || mr;
        w   = -1;
        for (int k = 0; k < 3; k++) begin
            int j;
            j = (m_ptr + k) % 3;
            if (w < 0 && v[j]) w = j;
        end
        hs = can && (w >= 0);
        er = hs ? 3'(1 << w) : 3'b000;
        chk("req_ready", {29'd0, o_req_ready}, {29'd0, er});
        if (hs) begin
            q.push_back({addr_tab[w], 2'(w)});
            m_valid = 1'b1;
            m_addr  = addr_tab[w];
            m_id    = 2'(w);
`ifdef MEM_ARB_RR_EN
            m_ptr = (w + 1) % 3;
`endif
        end else if (mr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (hs) begin
            e = q.pop_front();
            chk("mem_addr", o_mem_addr, e[33:2]);
            chk("mem_id", {30'd0, o_mem_id}, {30'd0, e[1:0]});
        end
        chk("mem_valid", {31'd0, o_mem_valid}, {31'd0, m_valid});
        chk("addr_hold", o_mem_addr, m_addr);
        chk("id_hold", {30'd0, o_mem_id}, {30'd0, m_id});
    endtask

    initial begin
        arstn       = 1'b0;
        i_req_valid = 3'b111;
        i_mem_ready = 1'b1;
        i_req_addr  = '0;
        addr_tab[0] = 32'h0000_1000;
        addr_tab[1] = 32'h0000_2000;
        addr_tab[2] = 32'h0000_3000;
        model_reset();

        // Reset state, ready held low despite valid requests
        #12;
        chk("rst_valid", {31'd0, o_mem_valid}, 32'd0);
        chk("rst_addr", o_mem_addr, 32'd0);
        chk("rst_id", {30'd0, o_mem_id}, 32'd0);
        chk("rst_ready", {29'd0, o_req_ready}, 32'd0);
        @(negedge clk);
        arstn = 1'b1;

        // Single request from requester 1
        step(3'b010, 1'b1);
        chk("single_addr", o_mem_addr, 32'h0000_2000);
        chk("single_id", {30'd0, o_mem_id}, 32'd1);
        step(3'b000, 1'b1);

        // All requesters valid, memory always ready
        for (int i = 0; i < 6; i++) step(3'b111, 1'b1);

        // Stall: FULL with id 2 / 0x40, memory not ready for 4 cycles
        addr_tab[2] = 32'h0000_0040;
        step(3'b100, 1'b1);
        chk("stall_id", {30'd0, o_mem_id}, 32'd2);
        for (int i = 0; i < 4; i++) step(3'b001, 1'b0);
        chk("stall_addr", o_mem_addr, 32'h0000_0040);
        step(3'b001, 1'b1);
        chk("stall_release_id", {30'd0, o_mem_id}, 32'd0);

        // Wrap: grant 1 moves ptr to 2, then only req0, then req1 vs req2
        step(3'b010, 1'b1);
        step(3'b001, 1'b1);
        step(3'b110, 1'b1);
        chk("wrap_id", {30'd0, o_mem_id}, 32'd1);

        // Drain
        step(3'b000, 1'b1);
        chk("drain_valid", {31'd0, o_mem_valid}, 32'd0);
        chk("drain_addr", o_mem_addr, 32'h0000_2000);
        step(3'b000, 1'b1);

        // Asynchronous reset while FULL with 0x100
        addr_tab[0] = 32'h0000_0100;
        step(3'b001, 1'b1);
        step(3'b001, 1'b0);
        arstn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, o_mem_valid}, 32'd0);
        chk("arst_addr", o_mem_addr, 32'd0);
        chk("arst_id", {30'd0, o_mem_id}, 32'd0);
        chk("arst_ready", {29'd0, o_req_ready}, 32'd0);
        model_reset();
        @(negedge clk);
        arstn = 1'b1;
        step(3'b111, 1'b1);
        chk("post_rst_id", {30'd0, o_mem_id}, 32'd0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            addr_tab[i % 3] = $urandom;
            step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_addr_arbiter.md
# mem_addr_arbiter

Parametrised N-requester memory address arbiter with a one-entry registered output stage and valid/ready handshakes on both sides. Sits between the core's address sources (PC fetch, load/store result, and future requesters such as a page walker) and the memory port. It replaces the fixed two-source address select with arbitration, so that multiple outstanding sources can share one memory interface without combinational paths from requesters to memory.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width in bits
- N_REQ, 3, number of requesters, ≥1
- IDW, max(1, $clog2(N_REQ)), derived width of the requester ID; not overridable

Ports:
- clk  input  1  single clock, rising edge
- arstn  input  1  asynchronous active-low reset
- i_req_valid  input  N_REQ  per-requester request valid
- i_req_addr  input  N_REQ×ADDR_WIDTH  packed [N_REQ-1:0][ADDR_WIDTH-1:0] request addresses
- o_req_ready  output  N_REQ  one-hot acceptance; at most one bit high per cycle
- o_mem_valid  output  1  output stage holds a request
- o_mem_addr  output  ADDR_WIDTH  registered winning address
- o_mem_id  output  IDW  index of the requester that owns o_mem_addr
- i_mem_ready  input  1  memory accepts o_mem_addr this cycle

## Operation
- Output stage: two states. EMPTY is o_mem_valid=0. FULL is o_mem_valid=1.
- can_load = ~o_mem_valid | i_mem_ready.
- Each cycle, the arbiter picks winner w from i_req_valid.
  - o_req_ready[w] = can_load & i_req_valid[w]. All other bits are 0.
- On a handshake i_req_valid[w] & o_req_ready[w]:
  - o_mem_addr ← i_req_addr[w]
  - o_mem_id ← w
  - o_mem_valid ← 1
- Transitions:
  - EMPTY → FULL on a handshake.
  - FULL → EMPTY when i_mem_ready=1 and there is no handshake.
  - FULL → FULL (reloaded) when i_mem_ready=1 and there is a handshake. This gives back-to-back issue with no bubble.
  - FULL with i_mem_ready=0: o_mem_addr and o_mem_id hold stable, and all o_req_ready bits are 0.
- Requester rule: once i_req_valid is raised, it and its address are held until ready. The arbiter does not check this rule.
- Arbitration: round-robin (see Configuration).
  - Pointer ptr is the highest-priority index. Search order is ptr, ptr+1, …, wrapping modulo N_REQ.
  - After a handshake with winner w, ptr ← (w+1) mod N_REQ. Wrap: w=N_REQ-1 gives ptr=0.
  - ptr does not change when there is no handshake, including when the output stage is stalled.
- N_REQ=1: the arbiter reduces to a registered pipe. o_mem_id is constantly 0.
- No request valid: no ready bits are asserted and the state is unchanged, apart from the drain to EMPTY.

## Timing
- Reset (async assert, sync-safe deassert assumed upstream):
  - o_mem_valid=0, o_mem_addr=0, o_mem_id=0, ptr=0
  - o_req_ready is 0 while arstn=0.
- Reset mid-operation: the pending output request is dropped immediately and asynchronously, and o_mem_valid falls without waiting for a clock edge.
- Latency: a request accepted at edge N appears on o_mem_* after edge N, i.e. in the next cycle.
- Throughput: one request per cycle when i_mem_ready=1 continuously.
- o_req_ready depends combinationally on i_req_valid, ptr, o_mem_valid and i_mem_ready.
- o_mem_* are pure register outputs.

## Configuration
- MEM_ARB_RR_EN defined: round-robin with the rotating ptr, as described above.
- MEM_ARB_RR_EN undefined: fixed priority, with index 0 highest. There is no ptr register. All other behaviour is identical.

## Structure
- Package mem_arb_pkg holds:
  - the state enum: EMPTY, FULL
  - the function computing IDW from N_REQ
- Sub-module rr_arbiter, parametrised by N_REQ:
  - inputs: request vector, enable
  - outputs: one-hot grant, binary grant index
  - owns ptr and the MEM_ARB_RR_EN switch
- The top level holds the output register and the handshake logic.

## Test plan
- Reset: drive arstn=0 mid-FULL with o_mem_addr=0x100 → o_mem_valid=0, o_mem_addr=0, o_mem_id=0 immediately. After release, the first grant goes to requester 0.
- Single request: req1 valid with 0x0000_2000, i_mem_ready=1 → o_req_ready=3'b010 in that cycle. Next cycle o_mem_valid=1, addr=0x2000, id=1.
- Round-robin: all three valid continuously, i_mem_ready=1 → grants 0,1,2,0,1,2 on consecutive cycles with no bubble.
  - With MEM_ARB_RR_EN undefined → grants stay 0,0,0.
- Stall: FULL with id=2, addr=0x40, i_mem_ready=0 for 4 cycles while req0 is valid → o_req_ready=0, outputs stable, ptr unchanged. On i_mem_ready=1, req0 is accepted in the same cycle.
- Wrap: ptr=2, only req0 valid → req0 granted and ptr becomes 1. Then req1 and req2 both valid → req1 wins.
- Drain: FULL, i_mem_ready=1, no valid requests → o_mem_valid=0 next cycle and o_mem_addr holds its last value.
